// File: rtl/imhotep_pkg.sv
// Shared types and sizing for the imhotep load/store path.
// Also holds the alignment rule used by data_ram for its error responses.
package imhotep_pkg;

    localparam int XLEN           = 32;
    localparam int RAM_WIDTH      = 32;
    localparam int DATA_RAM_DEPTH = 1024;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        MERGE = 2'd2,
        RESP  = 2'd3
    } data_ram_state_e;

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        case (size)
            MEM_H:   is_misaligned = off[0];
            MEM_W:   is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Combinational byte-lane logic for data_ram.
// Produces the right-aligned read value and the merged word for sub-word stores.
module ram_lane_align
    import imhotep_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [XLEN-1:0] i_data,
    input  logic [1:0]      i_off,
    input  mem_size_e       i_size,
    output logic [XLEN-1:0] o_rdata,
    output logic [XLEN-1:0] o_merged
);

    logic [4:0]      w_sh;
    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_lanes;

    assign w_sh = {i_off, 3'b000};

    always_comb begin
        w_mask = '1;
        case (i_size)
            MEM_B:   w_mask = XLEN'(32'h0000_00FF);
            MEM_H:   w_mask = XLEN'(32'h0000_FFFF);
            default: w_mask = '1;
        endcase
    end

    assign w_lanes  = w_mask << w_sh;
    assign o_rdata  = (i_word >> w_sh) & w_mask;
    assign o_merged = (i_word & ~w_lanes) | ((i_data & w_mask) << w_sh);

endmodule

// File: rtl/data_ram.sv
// Load/store memory responder with fixed latency and sub-word read-modify-write.
// Define DATA_RAM_BOUNDS_CHECK_EN to flag word indices >= DEPTH as errors instead of wrapping.
module data_ram
    import imhotep_pkg::*;
#(
    parameter int DEPTH   = DATA_RAM_DEPTH,
    parameter int LATENCY = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 ready_o,
    input  logic                 w_rn_i,
    input  mem_size_e            size_i,
    input  logic [RAM_WIDTH-1:0] addr_i,
    input  logic [XLEN-1:0]      value_i,
    output logic                 valid_o,
    output logic [XLEN-1:0]      value_o,
    output logic                 error_o
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    data_ram_state_e      r_state, w_next;
    logic                 r_wr;
    mem_size_e            r_size;
    logic [RAM_WIDTH-1:0] r_addr;
    logic [XLEN-1:0]      r_data;
    logic [3:0]           r_cnt;
    logic [XLEN-1:0]      r_mem [DEPTH];

    logic                 w_idle, w_wr, w_err, w_oob, w_sub, w_mem_we;
    mem_size_e            w_size;
    logic [RAM_WIDTH-1:0] w_addr;
    logic [XLEN-1:0]      w_data, w_word, w_rdata, w_merged, w_mem_wd;
    logic [AW-1:0]        w_idx;
    logic [3:0]           w_cnt_dec;

    // In IDLE the live inputs are used so a LATENCY=1 word write can commit on the accept edge.
    assign w_idle = (r_state == IDLE);
    assign w_wr   = w_idle ? w_rn_i  : r_wr;
    assign w_size = w_idle ? size_i  : r_size;
    assign w_addr = w_idle ? addr_i  : r_addr;
    assign w_data = w_idle ? value_i : r_data;
    assign w_idx  = w_addr[AW+1:2];

`ifdef DATA_RAM_BOUNDS_CHECK_EN
    assign w_oob = ({2'b00, w_addr[RAM_WIDTH-1:2]} >= RAM_WIDTH'(DEPTH));
`else
    logic w_unused_hi;
    assign w_unused_hi = ^w_addr[RAM_WIDTH-1:AW+2];
    assign w_oob       = 1'b0;
`endif

    assign w_err     = is_misaligned(w_size, w_addr[1:0]) | w_oob;
    assign w_sub     = w_wr && (w_size != MEM_W) && !w_err;
    assign w_cnt_dec = r_cnt - 4'd1;
    assign w_word    = r_mem[w_idx];

    ram_lane_align u_align (
        .i_word   (w_word),
        .i_data   (w_data),
        .i_off    (w_addr[1:0]),
        .i_size   (w_size),
        .o_rdata  (w_rdata),
        .o_merged (w_merged)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    if (LATENCY > 1) w_next = WAIT;
                    else if (w_sub)  w_next = MERGE;
                    else             w_next = RESP;
                end
            end
            WAIT: begin
                if (w_cnt_dec == 4'd0) w_next = w_sub ? MERGE : RESP;
            end
            MERGE:   w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    assign w_mem_we = (r_state == MERGE) ||
                      (w_wr && (w_size == MEM_W) && !w_err && (w_next == RESP) &&
                       (r_state == IDLE || r_state == WAIT));
    assign w_mem_wd = (r_state == MERGE) ? w_merged : w_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
            r_size  <= MEM_B;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_idle && req_i) begin
                r_wr   <= w_rn_i;
                r_size <= size_i;
                r_addr <= addr_i;
                r_data <= value_i;
                r_cnt  <= LAT_M1;
            end else if (r_state == WAIT) begin
                r_cnt  <= w_cnt_dec;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_we) r_mem[w_idx] <= w_mem_wd;
    end

    assign ready_o = w_idle;
    assign valid_o = (r_state == RESP);
    assign error_o = valid_o && w_err;
    assign value_o = (valid_o && !r_wr && !w_err) ? w_rdata : '0;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: one instance at LATENCY=1 and one at LATENCY=3.
// Responses are timed in cycles after the accept edge; expected values are hand-computed.
module tb_data_ram;
    import imhotep_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 req1 = 1'b0, req3 = 1'b0;
    logic                 w_rn = 1'b0;
    mem_size_e            size = MEM_W;
    logic [RAM_WIDTH-1:0] addr = '0;
    logic [XLEN-1:0]      wdata = '0;

    logic            ready1, valid1, err1, ready3, valid3, err3;
    logic [XLEN-1:0] val1, val3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_ram #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .ready_o(ready1), .w_rn_i(w_rn),
        .size_i(size), .addr_i(addr), .value_i(wdata), .valid_o(valid1),
        .value_o(val1), .error_o(err1));

    data_ram #(.DEPTH(1024), .LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .ready_o(ready3), .w_rn_i(w_rn),
        .size_i(size), .addr_i(addr), .value_i(wdata), .valid_o(valid3),
        .value_o(val3), .error_o(err3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on the selected instance; exp_lat counts cycles after the accept edge.
    task automatic access(input int sel, input logic wr, input mem_size_e sz,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_val, input logic exp_err,
                          input int exp_lat, input string tag);
        int  n;
        bit  got;
        bit  rdy_low;
        @(negedge clk);
        w_rn  = wr;
        size  = sz;
        addr  = a;
        wdata = d;
        chk({tag, ".ready_before"}, {31'd0, (sel == 1) ? ready1 : ready3}, 32'd1);
        if (sel == 1) req1 = 1'b1; else req3 = 1'b1;
        @(posedge clk);
        #1;
        req1 = 1'b0;
        req3 = 1'b0;
        n       = 1;
        got     = 1'b0;
        rdy_low = 1'b1;
        while (n <= 20 && !got) begin
            if (((sel == 1) ? ready1 : ready3) !== 1'b0) rdy_low = 1'b0;
            if (((sel == 1) ? valid1 : valid3) === 1'b1) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk({tag, ".valid_seen"}, {31'd0, got}, 32'd1);
        chk({tag, ".latency"}, n, exp_lat);
        chk({tag, ".ready_low"}, {31'd0, rdy_low}, 32'd1);
        chk({tag, ".value"}, (sel == 1) ? val1 : val3, exp_val);
        chk({tag, ".error"}, {31'd0, (sel == 1) ? err1 : err3}, {31'd0, exp_err});
        @(posedge clk);
        #1;
        chk({tag, ".valid_pulse"}, {31'd0, (sel == 1) ? valid1 : valid3}, 32'd0);
        chk({tag, ".ready_after"}, {31'd0, (sel == 1) ? ready1 : ready3}, 32'd1);
    endtask

    initial begin
        #12;
        chk("rst.ready", {31'd0, ready1}, 32'd1);
        chk("rst.valid", {31'd0, valid1}, 32'd0);
        chk("rst.value", val1, 32'd0);
        chk("rst.error", {31'd0, err1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // LATENCY=1
        access(1, 1'b1, MEM_W, 32'h10, 32'hDEAD_BEEF, 32'h0,        1'b0, 1, "l1_ww");
        access(1, 1'b0, MEM_W, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, "l1_rw");
        access(1, 1'b1, MEM_B, 32'h12, 32'h0000_00A5, 32'h0,        1'b0, 2, "l1_wb");
        access(1, 1'b0, MEM_W, 32'h10, 32'h0,         32'hDEA5_BEEF, 1'b0, 1, "l1_rw2");
        access(1, 1'b0, MEM_B, 32'h12, 32'h0,         32'h0000_00A5, 1'b0, 1, "l1_rb");
        access(1, 1'b0, MEM_H, 32'h12, 32'h0,         32'h0000_DEA5, 1'b0, 1, "l1_rh");
        access(1, 1'b1, MEM_W, 32'h11, 32'h1111_1111, 32'h0,        1'b1, 1, "l1_mis_w");
        access(1, 1'b0, MEM_H, 32'h13, 32'h0,         32'h0,        1'b1, 1, "l1_mis_rh");
        access(1, 1'b1, MEM_H, 32'h11, 32'h0000_7777, 32'h0,        1'b1, 1, "l1_mis_wh");
        access(1, 1'b0, MEM_W, 32'h10, 32'h0,         32'hDEA5_BEEF, 1'b0, 1, "l1_after_mis");

        // reset during MERGE of a byte write
        @(negedge clk);
        w_rn  = 1'b1;
        size  = MEM_B;
        addr  = 32'h10;
        wdata = 32'h0000_0077;
        req1  = 1'b1;
        @(posedge clk);
        #1;
        req1 = 1'b0;
        chk("rst_mid.in_merge", {31'd0, ready1}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid.ready", {31'd0, ready1}, 32'd1);
        chk("rst_mid.valid", {31'd0, valid1}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid.no_resp", {31'd0, valid1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        access(1, 1'b0, MEM_W, 32'h10, 32'h0, 32'hDEA5_BEEF, 1'b0, 1, "rst_mid.word");

        // out-of-range index
        access(1, 1'b1, MEM_W, 32'h0, 32'h1234_5678, 32'h0, 1'b0, 1, "l1_w0");
`ifdef DATA_RAM_BOUNDS_CHECK_EN
        access(1, 1'b0, MEM_W, 32'h1000, 32'h0, 32'h0,         1'b1, 1, "bounds");
`else
        access(1, 1'b0, MEM_W, 32'h1000, 32'h0, 32'h1234_5678, 1'b0, 1, "bounds");
`endif

        // LATENCY=3, back-to-back accepts exercise the counter reload
        access(3, 1'b1, MEM_W, 32'h10, 32'hDEAD_BEEF, 32'h0,        1'b0, 3, "l3_ww");
        access(3, 1'b1, MEM_B, 32'h12, 32'h0000_00A5, 32'h0,        1'b0, 4, "l3_wb");
        access(3, 1'b0, MEM_H, 32'h12, 32'h0,         32'h0000_DEA5, 1'b0, 3, "l3_rh");
        access(3, 1'b0, MEM_B, 32'h13, 32'h0,         32'h0000_00DE, 1'b0, 3, "l3_rb");
        access(3, 1'b1, MEM_H, 32'h10, 32'h0000_1234, 32'h0,        1'b0, 4, "l3_wh");
        access(3, 1'b0, MEM_W, 32'h10, 32'h0,         32'hDEA5_1234, 1'b0, 3, "l3_rw");
        access(3, 1'b0, MEM_W, 32'h12, 32'h0,         32'h0,        1'b1, 3, "l3_mis");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
